// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants, FSM state encoding and modular-arithmetic
//                helpers for the PWM capture block.
//                  PWM_PERIOD - length of the shared period counter (500)
//                  CNT_W      - width of counter values / timestamps (9)
//                  PHASE_W    - width of the reported phase (8)
//                  AMP_W      - width of the reported amplitude (7)
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int PWM_PERIOD = 500;
    localparam int CNT_W      = 9;
    localparam int PHASE_W    = 8;
    localparam int AMP_W      = 7;

    // Capture FSM states.
    typedef enum logic [0:0] {
        PWM_IDLE = 1'b0,
        PWM_HIGH = 1'b1
    } pwm_state_e;

    // (a - b) mod PWM_PERIOD for a, b in 0..PWM_PERIOD-1.
    // The difference is formed in 10 bits; a negative result shows up as
    // bit 9 set, and a single +PWM_PERIOD brings it back into range.
    function automatic logic [CNT_W-1:0] pwm_mod_sub(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[CNT_W]) begin
            diff = diff + (CNT_W+1)'(PWM_PERIOD);
        end
        return diff[CNT_W-1:0];
    endfunction

    // Half of the pulse width, saturated to the amplitude range.
    function automatic logic [AMP_W-1:0] pwm_amp(
        input logic [CNT_W-2:0] half_width
    );
        logic [AMP_W-1:0] amp_v;
        if (half_width > (CNT_W-1)'((1 << AMP_W) - 1)) begin
            amp_v = '1;
        end else begin
            amp_v = half_width[AMP_W-1:0];
        end
        return amp_v;
    endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_cap_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_cap_sync
//  Description : Input conditioning for the PWM capture block. Brings the
//                asynchronous waveform into the clk domain, optionally
//                de-glitches it, and produces registered rise/fall strobes.
//
//  Configuration macro:
//    PWM_CAP_FILTER_EN  - when defined, a 3-sample majority-free filter follows
//                         the synchronizer: the level only changes after three
//                         consecutive equal samples (adds 2 cycles latency).
//
//  Ports:
//    clk      in   system clock
//    nReset   in   synchronous active-low reset
//    i_din    in   asynchronous PWM waveform
//    o_rise   out  one-cycle strobe: conditioned level went 0 -> 1
//    o_fall   out  one-cycle strobe: conditioned level went 1 -> 0
//    o_low    out  conditioned level is a genuine (post-reset) low sample
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_cap_sync
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nReset,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall,
    output logic o_low
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_level;
    logic                   r_dly;
    logic                   r_rise;
    logic                   r_fall;
    logic [2:0]             r_prime;
    logic                   w_primed;

    // ------------------------------------------------------------------------
    // Synchronizer chain
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
    // ------------------------------------------------------------------------
    // 3-sample filter. The current sample plus the two previous ones must
    // agree before the level follows; otherwise the last accepted level holds.
    // The filtered level is combinational so the filter costs exactly two
    // extra cycles of latency (the two history flops).
    // ------------------------------------------------------------------------
    localparam int PRIME_LEN = SYNC_STAGES + 2;

    logic [1:0] r_hist;
    logic       r_filt;

    assign w_level = ((w_sync == r_hist[0]) && (w_sync == r_hist[1]))
                     ? w_sync : r_filt;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_hist <= '0;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], w_sync};
            r_filt <= w_level;
        end
    end
`else
    localparam int PRIME_LEN = SYNC_STAGES;

    assign w_level = w_sync;
`endif

    // ------------------------------------------------------------------------
    // Priming counter. Right after reset the pipeline holds reset zeros, not
    // real samples of din; a low seen then must not arm the capture FSM, or a
    // pulse already in progress at reset release would be measured from the
    // wrong place.
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_prime_len = 3'(PRIME_LEN);

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_prime <= '0;
        end else if (r_prime != c_prime_len) begin
            r_prime <= r_prime + 3'd1;
        end
    end

    assign w_primed = (r_prime == c_prime_len);
    assign o_low    = w_primed & ~w_level;

    // ------------------------------------------------------------------------
    // Edge detect against a one-cycle delayed copy; strobes are registered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_dly  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_dly  <= w_level;
            r_rise <= w_level & ~r_dly;
            r_fall <= ~w_level & r_dly;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule : pwm_cap_sync
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures the rise position and high width of an asynchronous
//                PWM waveform against a shared 0..499 period counter.
//
//  Configuration macro:
//    PWM_CAP_FILTER_EN  - enables the 3-sample input filter in pwm_cap_sync
//                         (glitches/gaps under 3 cycles rejected, +2 latency).
//
//  Parameters:
//    SYNC_STAGES  number of input synchronizer flops (2..3)
//
//  Ports:
//    clk      in   system clock, rising edge
//    nReset   in   synchronous active-low reset
//    cnt      in   [8:0] shared period counter, 0..499 (500..511 read as 0)
//    din      in   asynchronous PWM waveform
//    valid    out  one-cycle strobe: phase/amp/width updated
//    phase    out  [7:0] rise timestamp / 2
//    amp      out  [6:0] width / 2, saturated at 127
//    width    out  [8:0] high time in clk cycles, 1..499
//    lost     out  sticky: a full period elapsed without a valid pulse
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic [CNT_W-1:0]   cnt,
    input  logic               din,
    output logic               valid,
    output logic [PHASE_W-1:0] phase,
    output logic [AMP_W-1:0]   amp,
    output logic [CNT_W-1:0]   width,
    output logic               lost
);

    // Cycles between din changing and its strobe reaching the FSM: the
    // synchronizer, the registered edge strobe, and the optional filter.
`ifdef PWM_CAP_FILTER_EN
    localparam int LAT = SYNC_STAGES + 3;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif

    localparam logic [CNT_W-1:0] c_lat     = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] c_period  = CNT_W'(PWM_PERIOD);
    localparam logic [CNT_W-1:0] c_age_max = CNT_W'(PWM_PERIOD - 1);

    localparam logic [0:0] S_IDLE = PWM_IDLE;
    localparam logic [0:0] S_HIGH = PWM_HIGH;

    logic               w_rise;
    logic               w_fall;
    logic               w_low;

    logic [0:0]         r_state;
    logic               r_armed;
    logic [CNT_W-1:0]   r_age;
    logic [CNT_W-1:0]   r_rise_cnt;

    logic               r_valid;
    logic [PHASE_W-1:0] r_phase;
    logic [AMP_W-1:0]   r_amp;
    logic [CNT_W-1:0]   r_width;
    logic               r_lost;

    logic [CNT_W-1:0]   w_cnt_eff;
    logic [CNT_W-1:0]   w_ts;
    logic [CNT_W-1:0]   w_width;
    logic               w_timeout;
    logic               w_rise_accept;
    logic               w_fall_accept;

    // ------------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------------
    pwm_cap_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .nReset (nReset),
        .i_din  (din),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_low  (w_low)
    );

    // ------------------------------------------------------------------------
    // Timestamping: the strobe seen now belongs to the edge LAT cycles ago.
    // Out-of-range counter values are treated as the start of the period.
    // ------------------------------------------------------------------------
    assign w_cnt_eff = (cnt >= c_period) ? '0 : cnt;
    assign w_ts      = pwm_mod_sub(w_cnt_eff, c_lat);
    assign w_width   = pwm_mod_sub(w_ts, r_rise_cnt);

    assign w_timeout     = (r_age == c_age_max);
    assign w_rise_accept = (r_state == S_IDLE) && w_rise && r_armed;
    assign w_fall_accept = (r_state == S_HIGH) && w_fall;

    // ------------------------------------------------------------------------
    // Capture FSM, watchdog and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b0;
            r_age      <= '0;
            r_rise_cnt <= '0;
            r_valid    <= 1'b0;
            r_phase    <= '0;
            r_amp      <= '0;
            r_width    <= '0;
            r_lost     <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            if (w_low) begin
                r_armed <= 1'b1;
            end

            if (w_rise_accept) begin
                // A rise restarts the watchdog, so a steady waveform whose
                // rises are exactly one period apart never times out.
                r_rise_cnt <= w_ts;
                r_age      <= '0;
                r_state    <= S_HIGH;
            end else begin
                r_age <= w_timeout ? '0 : (r_age + CNT_W'(1));

                // A fall in the same cycle as the timeout still completes
                // the measurement.
                if (w_fall_accept) begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b1;
                    r_width <= w_width;
                    r_phase <= r_rise_cnt[CNT_W-1:1];
                    r_amp   <= pwm_amp(w_width[CNT_W-1:1]);
                    r_lost  <= 1'b0;
                end else if (w_timeout) begin
                    r_state <= S_IDLE;
                    r_lost  <= 1'b1;
                end
            end
        end
    end

    assign valid = r_valid;
    assign phase = r_phase;
    assign amp   = r_amp;
    assign width = r_width;
    assign lost  = r_lost;

endmodule : pwm_capture
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Self-checking bench for pwm_capture. Drives the shared
//                period counter and a PWM waveform built from rise/fall
//                positions; expected measurements go into a scoreboard queue
//                and are compared when the DUT strobes valid.
//                Honours PWM_CAP_FILTER_EN to match the DUT build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

`ifdef PWM_CAP_FILTER_EN
    localparam int TB_LAT = 5;
`else
    localparam int TB_LAT = 3;
`endif

    typedef struct {
        int rise;
        int fall;
        int ph;
        int am;
        int wd;
    } vec_t;

    typedef struct {
        int ph;
        int am;
        int wd;
    } exp_t;

    logic       clk;
    logic       nReset;
    logic [8:0] cnt;
    logic       din;
    logic       valid;
    logic [7:0] phase;
    logic [6:0] amp;
    logic [8:0] width;
    logic       lost;

    int   n_vec;
    int   n_err;
    int   cyc;
    int   last_rise;

    logic en;
    logic gl_en;
    int   pr;
    int   pf;

    exp_t sbq[$];
    exp_t m_e;
    vec_t vtab[$];

    pwm_capture #(
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .nReset (nReset),
        .cnt    (cnt),
        .din    (din),
        .valid  (valid),
        .phase  (phase),
        .amp    (amp),
        .width  (width),
        .lost   (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp_v);
        end
    endtask

    function automatic logic in_win(input int c, input int r, input int f);
        if (r <= f) return (c >= r) && (c < f);
        else        return (c >= r) || (c < f);
    endfunction

    function automatic logic drive_level(input int c);
        return (en && in_win(c, pr, pf)) || (gl_en && in_win(c, 10, 12));
    endfunction

    task automatic tick();
        logic prev;
        @(posedge clk);
        #1;
        prev = din;
        cnt  = (cnt == 9'd499) ? 9'd0 : cnt + 9'd1;
        din  = drive_level(int'(cnt));
        cyc++;
        if (din && !prev) last_rise = cyc;
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((int'(cnt) != v) && (n < 600));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 12 && sbq.size() != 0; i++) tick();
        check("valid_seen", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic push_exp(input int ph, input int am, input int wd);
        exp_t e;
        e.ph = ph; e.am = am; e.wd = wd;
        sbq.push_back(e);
    endtask

    // One isolated pulse from rise to fall, waveform otherwise low.
    task automatic apply_pulse(input vec_t v);
        en = 1'b0;
        pr = v.rise;
        pf = v.fall;
        push_exp(v.ph, v.am, v.wd);
        wait_cnt((v.rise + 499) % 500);
        en = 1'b1;
        wait_cnt(v.fall);
        en = 1'b0;
        wait_drain();
    endtask

    task automatic check_zero_outputs();
        check("rst_valid", valid, 0);
        check("rst_phase", phase, 0);
        check("rst_amp",   amp,   0);
        check("rst_width", width, 0);
        check("rst_lost",  lost,  0);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (nReset && valid) begin
            if (sbq.size() == 0) begin
                check("valid_unexpected", valid, 0);
            end else begin
                m_e = sbq.pop_front();
                check("phase", phase, m_e.ph);
                check("amp",   amp,   m_e.am);
                check("width", width, m_e.wd);
                check("lost_at_valid", lost, 0);
            end
        end
    end

    initial begin
        int elapsed;
        int k;

        n_vec = 0; n_err = 0; cyc = 0; last_rise = 0;
        en = 1'b0; gl_en = 1'b0; pr = 0; pf = 0;
        cnt = 9'd0; din = 1'b0; nReset = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check_zero_outputs();
        nReset = 1'b1;

        // ---------------- single-pulse table ----------------
        vtab.push_back('{250, 370, 125,  60, 120});
        vtab.push_back('{450,  30, 225,  40,  80});
        vtab.push_back('{ 10,  14,   5,   2,   4});
        vtab.push_back('{100, 353,  50, 126, 253});
        vtab.push_back('{100, 356,  50, 127, 256});
        vtab.push_back('{  0, 497,   0, 127, 497});
`ifndef PWM_CAP_FILTER_EN
        vtab.push_back('{ 10,  11,   5,   0,   1});
`endif
        foreach (vtab[i]) apply_pulse(vtab[i]);

        // ---------------- continuous 250/370 waveform ----------------
        pr = 250; pf = 370;
        wait_cnt(249);
        en = 1'b1;
        repeat (3) push_exp(125, 60, 120);
        repeat (3) wait_cnt(370);
        en = 1'b0;
        wait_drain();
        check("lost_steady", lost, 0);

        // ---------------- watchdog: din held low ----------------
        k = 0;
        while (!lost && k < 700) begin
            tick();
            k++;
        end
        elapsed = cyc - last_rise;
        check("lost_set", lost, 1);
        check("lost_delay", elapsed, 501 + TB_LAT);
        check("phase_hold", phase, 125);
        repeat (100) tick();
        check("lost_sticky", lost, 1);
        apply_pulse('{250, 370, 125, 60, 120});
        check("lost_cleared", lost, 0);

        // ---------------- din high across reset release ----------------
        wait_cnt(40);
        pr = 20; pf = 100; en = 1'b1;
        din = drive_level(int'(cnt));
        nReset = 1'b0;
        repeat (3) tick();
        nReset = 1'b1;
        wait_cnt(101);
        pr = 200; pf = 300;
        push_exp(100, 50, 100);
        wait_cnt(300);
        en = 1'b0;
        wait_drain();

        // ---------------- reset in the middle of a pulse ----------------
        pr = 250; pf = 370;
        wait_cnt(249);
        en = 1'b1;
        wait_cnt(300);
        nReset = 1'b0;
        repeat (2) tick();
        check_zero_outputs();
        nReset = 1'b1;
        push_exp(125, 60, 120);
        wait_cnt(370);
        wait_cnt(370);
        en = 1'b0;
        wait_drain();

`ifdef PWM_CAP_FILTER_EN
        // ---------------- 2-cycle glitch rejected by filter ----------------
        pr = 250; pf = 370;
        wait_cnt(5);
        en = 1'b1; gl_en = 1'b1;
        push_exp(125, 60, 120);
        wait_cnt(370);
        en = 1'b0; gl_en = 1'b0;
        wait_drain();
`endif

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pwm_capture
`default_nettype wire
